// File: rtl/regfile_dump_reader_if.sv
// Bundle of the regfile read-port handshake and the {addr,data} beat stream.
// The master side is the dump reader; the slave side is the regfile/hazard unit plus consumer.
interface regfile_dump_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  port_req;
    logic                  port_gnt;
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;

    // A beat transfers on a rising edge where out_valid && out_ready; out_addr/out_data
    // stay stable while out_valid is high and out_ready is low.
    modport master (
        output port_req, ra, out_valid, out_addr, out_data,
        input  port_gnt, rd, out_ready
    );

    modport slave (
        input  port_req, ra, out_valid, out_addr, out_data,
        output port_gnt, rd, out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks regfile entries FIRST_REG..LAST_REG through a borrowed read port and
// streams each one as an {addr,data} beat; all outputs are registers or state decodes.
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    regfile_dump_reader_if.master bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2:0]            state_o
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = REQ;
                    idx_d   = FIRST_IDX;
                end
            end
            REQ: begin
                if (bus.port_gnt) state_d = LOAD;
            end
            LOAD: begin
                // rd is only meaningful while the hazard unit has muxed ra onto a1.
                if (bus.port_gnt) begin
                    data_d  = bus.rd;
                    addr_d  = idx_q;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    // Compare before incrementing so LAST_REG = 2^ADDR_WIDTH-1 never wraps.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = FIRST_IDX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.port_req  = (state_q == REQ) || (state_q == LOAD) || (state_q == SEND);
    assign bus.out_valid = (state_q == SEND);
    assign bus.ra        = idx_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_data  = data_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign state_o       = state_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a cycle table for reset/handshake basics,
// then hand-written full-dump, back-pressure, grant-drop, abort and reset sequences.
module tb_regfile_dump_reader;
    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic [2:0] state_dbg;

    regfile_dump_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_dump_reader #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .FIRST_REG(0), .LAST_REG(31)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .abort_i (abort),
        .bus     (bus),
        .busy_o  (busy),
        .done_o  (done),
        .state_o (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- regfile model ----------------
    logic [31:0] regs [32];
    assign bus.rd = (bus.ra == 5'd0) ? 32'h0 : regs[bus.ra];

    function automatic logic [31:0] exp_reg(input int i);
        if (i == 0)  return 32'h0000_0000;
        if (i == 8)  return 32'hFFFF_FFFF;
        if (i == 10) return 32'h0000_ABCD;
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // ---------------- counters / scoreboard ----------------
    int n_vec;
    int n_fail;
    int done_cnt;
    bit sb_en;
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_q();
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), exp_reg(i)});
    endtask

    // Outputs and inputs are both stable at the falling edge; the handshake lands on the next rise.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (sb_en && rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL beat_unexpected: got addr %0d data %h expected none",
                         bus.out_addr, bus.out_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check($sformatf("beat_addr%0d", e[36:32]), 64'({bus.out_addr, bus.out_data}), 64'(e));
            end
        end
    end

    task automatic wait_beat(input logic [4:0] a, input int budget);
        for (int k = 0; k < budget; k++) begin
            step();
            if (bus.out_valid && bus.out_addr == a) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL wait_beat: got no beat within %0d cycles expected addr %0d", budget, a);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            cycles++;
            if (done) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL wait_done: got no done within %0d cycles expected done", budget);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, start, abort, gnt, ready;
        logic        req, valid, bsy, dn;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vt[18];

    initial begin
        int cyc;
        int d0;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        bus.port_gnt = 1'b0; bus.out_ready = 1'b0;
        n_vec = 0; n_fail = 0; done_cnt = 0; sb_en = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = exp_reg(i);
        regs[0] = 32'hDEAD_BEEF;  // regfile forces r0 to read zero regardless

        //       rst  st   ab   gnt  rdy  req  vld  bsy  dn   addr   data
        vt[0]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
        vt[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
        vt[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0,32'h0};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0,32'h0};
        vt[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0,32'h0};
        vt[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0,32'h0};
        vt[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,5'd0,32'h0};
        vt[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,5'd0,32'h0};
        vt[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0,32'h0};
        vt[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0,32'h0};
        vt[10] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,5'd1,32'hA5A5_0001};
        vt[11] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,5'd1,32'hA5A5_0001};
        vt[12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd1,32'hA5A5_0001};
        vt[13] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,5'd1,32'hA5A5_0001};
        vt[14] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,5'd1,32'hA5A5_0001};
        vt[15] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,5'd0,32'h0};
        vt[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};
        vt[17] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,32'h0};

        step();
        for (int i = 0; i < 18; i++) begin
            rst = vt[i].rst; start = vt[i].start; abort = vt[i].abort;
            bus.port_gnt = vt[i].gnt; bus.out_ready = vt[i].ready;
            step();
            check($sformatf("vec[%0d]", i),
                  64'({bus.port_req, bus.out_valid, busy, done, bus.out_addr, bus.out_data}),
                  64'({vt[i].req, vt[i].valid, vt[i].bsy, vt[i].dn, vt[i].addr, vt[i].data}));
        end
        start = 1'b0; abort = 1'b0;

        // Full dump with start re-pulsed mid-dump: 32 beats, one done.
        sb_en = 1'b1;
        bus.port_gnt = 1'b1; bus.out_ready = 1'b1;
        fill_q();
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(200, cyc);
        check("done_latency", 64'(cyc + 10), 64'd65);
        step();
        check("busy_after_done", 64'({busy, done, bus.port_req}), 64'd0);
        for (int k = 0; k < 6; k++) step();
        check("done_count_full", 64'(done_cnt - d0), 64'd1);
        check("beats_left_full", 64'(exp_q.size()), 64'd0);

        // Back-pressure on beat 8: valid and payload held for five cycles.
        fill_q();
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_beat(5'd8, 100);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("stall_hold%0d", k),
                  64'({bus.out_valid, bus.out_addr, bus.out_data}), 64'({1'b1, 5'd8, 32'hFFFF_FFFF}));
        end
        bus.out_ready = 1'b1;
        wait_done(200, cyc);
        step();
        check("done_count_stall", 64'(done_cnt - d0), 64'd1);
        check("beats_left_stall", 64'(exp_q.size()), 64'd0);

        // Grant drop while loading r5, then abort at beat 12.
        fill_q();
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_beat(5'd4, 100);
        step();
        bus.port_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("gnt_drop%0d", k),
                  64'({bus.port_req, bus.out_valid, bus.ra}), 64'({1'b1, 1'b0, 5'd5}));
        end
        bus.port_gnt = 1'b1;
        wait_beat(5'd12, 100);
        bus.out_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_outputs", 64'({bus.port_req, bus.out_valid, busy, done}), 64'd0);
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Restart from r0 after the abort, then reset at beat 20.
        fill_q();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_beat(5'd20, 100);
        bus.out_ready = 1'b0;
        rst = 1'b0;
        step();
        check("reset_mid_dump",
              64'({bus.port_req, bus.out_valid, busy, done, bus.out_addr, bus.out_data}), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("reset_no_done", 64'(done_cnt - d0), 64'd0);
        check("reset_idle", 64'({busy, bus.out_valid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
